// File: rtl/cla_pipe_addsub_pkg.sv
// cla_pipe_addsub_pkg: shared constants and parameter legality check for the pipelined CLA adder/subtractor.
package cla_pipe_addsub_pkg;
  localparam int GRP_W = 4;
  function automatic bit cfg_ok(input int width, input int seg_w);
    return seg_w > 0 && seg_w % GRP_W == 0 && width % seg_w == 0;
  endfunction
endpackage

// File: rtl/cla_group4.sv
// cla_group4: combinational 4-bit carry-lookahead group, also exposing the carry into bit 3.
module cla_group4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o,
  output logic       c3_o
);
  logic [3:0] g, p, c;
  assign g = a_i & b_i;
  assign p = a_i ^ b_i;
  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | ((&p[2:0]) & c[0]);
  assign cout_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | ((&p[3:1]) & g[0]) | ((&p) & c[0]);
  assign sum_o = p ^ c;
  assign c3_o = c[3];
endmodule

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined carry-lookahead adder/subtractor, one SEG_W-bit segment resolved per stage,
// with valid/ready flow control and carry/overflow/zero flags.
module cla_pipe_addsub
  import cla_pipe_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int NSEG = WIDTH / SEG_W;
  localparam int NGRP = SEG_W / GRP_W;
  if (!cfg_ok(WIDTH, SEG_W)) begin : g_bad_cfg
    $error("cla_pipe_addsub: WIDTH must be a multiple of SEG_W and SEG_W a multiple of 4");
  end
  logic                          adv, acc, m_q, m_w;
  logic [WIDTH-1:0]              a_q [NSEG];
  logic [WIDTH-1:0]              b_q [NSEG];
  logic [WIDTH-1:0]              s_q [NSEG+1];
  logic [NSEG-1:0]               z_q [NSEG+1];
  logic [NSEG:0]                 v_q, c_q;
  logic [NSEG-1:0][SEG_W-1:0]    seg_s;
  logic [NSEG-1:0]               seg_c;
  assign adv = !v_q[NSEG] | out_ready;
  assign in_ready = adv & !rst;
  assign acc = in_valid & in_ready;
  // Segment s reads stage-s registers and produces the stage-(s+1) slice.
  for (genvar s = 0; s < NSEG; s++) begin : g_seg
    logic [NGRP:0] gc;
    assign gc[0] = c_q[s];
    assign seg_c[s] = gc[NGRP];
    for (genvar g = 0; g < NGRP; g++) begin : g_grp
      if (s == NSEG-1 && g == NGRP-1) begin : g_msb
        cla_group4 u_grp (
          .a_i(a_q[s][s*SEG_W+g*GRP_W +: GRP_W]), .b_i(b_q[s][s*SEG_W+g*GRP_W +: GRP_W]),
          .cin_i(gc[g]), .sum_o(seg_s[s][g*GRP_W +: GRP_W]), .cout_o(gc[g+1]), .c3_o(m_w)
        );
      end else begin : g_lsb
        logic c3_unused;
        cla_group4 u_grp (
          .a_i(a_q[s][s*SEG_W+g*GRP_W +: GRP_W]), .b_i(b_q[s][s*SEG_W+g*GRP_W +: GRP_W]),
          .cin_i(gc[g]), .sum_o(seg_s[s][g*GRP_W +: GRP_W]), .cout_o(gc[g+1]), .c3_o(c3_unused)
        );
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 0; k <= NSEG; k++) begin
        s_q[k] <= '0;
        z_q[k] <= '0;
      end
      v_q <= '0;
      c_q <= '0;
      m_q <= 1'b0;
    end else if (adv) begin
      a_q[0] <= in_a;
      b_q[0] <= in_sub ? ~in_b : in_b;
      v_q <= {v_q[NSEG-1:0], acc};
      c_q <= {seg_c, in_sub | in_cin};
      m_q <= m_w;
      for (int k = 1; k < NSEG; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
      for (int k = 1; k <= NSEG; k++) begin
        s_q[k] <= s_q[k-1];
        s_q[k][(k-1)*SEG_W +: SEG_W] <= seg_s[k-1];
        z_q[k] <= z_q[k-1];
        z_q[k][k-1] <= ~|seg_s[k-1];
      end
    end
  end
  assign out_valid = v_q[NSEG];
  assign out_sum = s_q[NSEG];
  assign out_cout = c_q[NSEG];
  assign out_ovf = m_q ^ c_q[NSEG];
  assign out_zero = &z_q[NSEG];
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb_cla_pipe_addsub: scoreboard bench for the 16/8 default build and an exhaustive 4/4 build.
module tb_cla_pipe_addsub;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        in_valid, in_ready, in_cin, in_sub, out_valid, out_ready, out_cout, out_ovf, out_zero;
  logic [15:0] in_a, in_b, out_sum;
  logic        in_valid4, in_ready4, in_cin4, in_sub4, out_valid4, out_ready4, out_cout4, out_ovf4, out_zero4;
  logic [3:0]  in_a4, in_b4, out_sum4;
  logic        rnd4 = 1'b0;
  int          checks = 0, errors = 0, popped = 0;
  logic [18:0] q16[$];
  logic [6:0]  q4[$];
  logic [18:0] held;
  logic        stalled = 1'b0;

  cla_pipe_addsub #(.WIDTH(16), .SEG_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );
  cla_pipe_addsub #(.WIDTH(4), .SEG_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_a(in_a4), .in_b(in_b4),
    .in_cin(in_cin4), .in_sub(in_sub4), .out_valid(out_valid4), .out_ready(out_ready4), .out_sum(out_sum4),
    .out_cout(out_cout4), .out_ovf(out_ovf4), .out_zero(out_zero4)
  );

  function automatic logic [6:0] model4(input logic [3:0] a, b, input logic cin, sub);
    logic [3:0] bb, s;
    logic co;
    bb = sub ? ~b : b;
    {co, s} = {1'b0, a} + {1'b0, bb} + {4'd0, sub | cin};
    return {s, co, (a[3] == bb[3]) && (s[3] != a[3]), s == 4'd0};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL in_ready got %b want %b", in_ready, !out_valid || out_ready);
      end
    end
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL out16 unexpected beat got sum=%h", out_sum);
      end else begin
        logic [18:0] e;
        e = q16.pop_front();
        popped++;
        if ({out_sum, out_cout, out_ovf, out_zero} !== e) begin
          errors++;
          $display("FAIL out16 got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                   out_sum, out_cout, out_ovf, out_zero, e[18:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (stalled && !rst) begin
      checks++;
      if ({out_valid, out_sum, out_cout, out_ovf, out_zero} !== {1'b1, held}) begin
        errors++;
        $display("FAIL stall_hold got v=%b sum=%h want v=1 sum=%h", out_valid, out_sum, held[18:3]);
      end
    end
    stalled = out_valid && !out_ready && !rst;
    held = {out_sum, out_cout, out_ovf, out_zero};
  end

  always @(negedge clk) begin
    if (!rst && out_valid4 && out_ready4) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL out4 unexpected beat got sum=%h", out_sum4);
      end else begin
        logic [6:0] e;
        e = q4.pop_front();
        if ({out_sum4, out_cout4, out_ovf4, out_zero4} !== e) begin
          errors++;
          $display("FAIL out4 got %b_%b%b%b want %b_%b%b%b", out_sum4, out_cout4, out_ovf4, out_zero4,
                   e[6:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd4) out_ready4 = $urandom_range(0, 3) != 0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic send(input logic [15:0] a, b, input logic cin, sub, input logic [18:0] e);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        q16.push_back(e);
        break;
      end
      if (++n > 100) begin
        checks++; errors++;
        $display("FAIL send16 timeout");
        break;
      end
    end
  endtask

  task automatic send4(input logic [3:0] a, b, input logic cin, sub);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    in_valid4 = 1'b1; in_a4 = a; in_b4 = b; in_cin4 = cin; in_sub4 = sub;
    forever begin
      @(negedge clk);
      if (in_ready4) begin
        q4.push_back(model4(a, b, cin, sub));
        break;
      end
      if (++n > 100) begin
        checks++; errors++;
        $display("FAIL send4 timeout");
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_valid4 = 1'b0;
  endtask

  task automatic drain(input bit w4);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if ((w4 ? q4.size() : q16.size()) == 0) return;
    end
    checks++; errors++;
    $display("FAIL drain%0s timeout left=%0d want 0", w4 ? "4" : "16", w4 ? q4.size() : q16.size());
  endtask

  initial begin
    int base;
    bit seen;
    in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; in_sub = 0; out_ready = 1;
    in_valid4 = 0; in_a4 = 0; in_b4 = 0; in_cin4 = 0; in_sub4 = 0; out_ready4 = 1;
    #1;
    checks++;
    if ({out_valid, out_sum, out_cout, out_ovf, out_zero, in_ready, out_valid4, out_sum4, in_ready4} !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b sum=%h rdy=%b v4=%b want all 0", out_valid, out_sum, in_ready, out_valid4);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(16'h0006, 16'h0005, 0, 0, {16'h000B, 3'b000});
    send(16'hFFFF, 16'hFFFF, 0, 0, {16'hFFFE, 3'b100});
    send(16'h00FF, 16'h0001, 0, 0, {16'h0100, 3'b000});
    send(16'h7FFF, 16'h0001, 0, 0, {16'h8000, 3'b010});
    send(16'h0004, 16'h0004, 0, 1, {16'h0000, 3'b101});
    send(16'h0000, 16'h0001, 0, 1, {16'hFFFF, 3'b000});
    send(16'hFFFF, 16'h0000, 1, 0, {16'h0000, 3'b101});
    send(16'h8000, 16'h0001, 0, 1, {16'h7FFF, 3'b110});
    send(16'h0010, 16'h0003, 1, 1, {16'h000D, 3'b100});
    send(16'h00FF, 16'hFF01, 0, 0, {16'h0000, 3'b101});
    send(16'h00FE, 16'h0001, 1, 0, {16'h0100, 3'b000});
    idle();
    drain(0);
    // Back-to-back beats; the consumer stalls for two cycles while beat 2 sits on the outputs.
    base = popped;
    fork
      begin
        send(16'h1111, 16'h2222, 0, 0, {16'h3333, 3'b000});
        send(16'hA000, 16'h6000, 0, 0, {16'h0000, 3'b101});
        send(16'h1234, 16'h0234, 0, 1, {16'h1000, 3'b100});
        send(16'h4000, 16'h4000, 0, 0, {16'h8000, 3'b010});
        idle();
      end
      begin
        seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
          @(negedge clk);
          #1;
          seen = popped == base + 1;
        end
        if (!seen) begin
          checks++; errors++;
          $display("FAIL stall_setup beat1 not seen");
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain(0);
    checks++;
    if (popped != base + 4) begin
      errors++;
      $display("FAIL stall_count got %0d want %0d", popped - base, 4);
    end
    // Async reset with beats in flight.
    send(16'h0001, 16'h0001, 0, 0, {16'h0002, 3'b000});
    send(16'h0002, 16'h0002, 0, 0, {16'h0004, 3'b000});
    idle();
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = out_valid;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_sum, out_zero, in_ready} !== '0 || !seen) begin
      errors++;
      $display("FAIL rst_async got v=%b sum=%h rdy=%b seen=%b want 0 0 0 1", out_valid, out_sum, in_ready, seen);
    end
    q16.delete();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL rst_ready got %b want 0", in_ready);
      end
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale got out_valid=%b want 0", out_valid);
      end
    end
    send(16'h0003, 16'h0004, 0, 0, {16'h0007, 3'b000});
    idle();
    drain(0);
    // Exhaustive 4-bit build with a randomly stalling consumer.
    rnd4 = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] v;
      v = i[9:0];
      send4(v[3:0], v[7:4], v[8], v[9]);
    end
    idle();
    drain(1);
    rnd4 = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
